// File: rtl/psram_cmd_queue_if.sv
// Client-side request/response channel and PsramController-side command channel of psram_cmd_queue.
// Request handshake: a request transfers on every clk edge where req_valid && req_ready; payload must be stable while req_valid is high.
interface psram_cmd_queue_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [21:0] req_addr;
  logic [15:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_write;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic [7:0]  rsp_byte;

  logic        mem_read;
  logic        mem_write;
  logic        mem_byte_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_busy;

  // Queue side.
  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_write, rsp_err, rsp_data, rsp_byte,
    output mem_read, mem_write, mem_byte_write, mem_addr, mem_din,
    input  mem_dout, mem_busy
  );

  // Client and controller side.
  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_write, rsp_err, rsp_data, rsp_byte,
    input  mem_read, mem_write, mem_byte_write, mem_addr, mem_din,
    output mem_dout, mem_busy
  );
endinterface

// File: rtl/psram_cmd_queue.sv
// In-order command queue feeding PsramController: one command in flight, per-command busy timeout, sticky error.
// Request handshake: push when req_valid && req_ready at a clk edge; req_ready = !full, independent of req_valid.
module psram_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  psram_cmd_queue_if.slave           bus,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [1:0]                 state_dbg
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  typedef struct packed {
    logic        write;
    logic        byte_w;
    logic [21:0] addr;
    logic [15:0] data;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  entry_t          new_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            done;
  logic            tmo;
  logic            cmd_write;
  logic [TW-1:0]   timer;
  state_t          state_q;
  state_t          state_d;

  assign state_dbg     = state_q;
  assign bus.req_ready = (level != LW'(DEPTH));
  assign push          = bus.req_valid && bus.req_ready;
  assign head          = fifo_q[rd_ptr];

  // Byte writes replicate the byte on both lanes so the controller can pick either.
  always_comb begin
    new_entry.write  = bus.req_write;
    new_entry.byte_w = bus.req_byte;
    new_entry.addr   = bus.req_addr;
    new_entry.data   = (bus.req_write && bus.req_byte) ?
                       {bus.req_wdata[7:0], bus.req_wdata[7:0]} : bus.req_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        // Waiting for !mem_busy also absorbs init and any transaction left over from a reset.
        if ((level != '0) && !bus.mem_busy) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = HOLD;
      // The controller raises busy a cycle after the pulse, so busy is not trusted here.
      HOLD:  state_d = WAIT;
      WAIT: begin
        if (!bus.mem_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          done    = 1'b1;
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (state_q == HOLD) begin
      timer <= '0;
    end else if (state_q == WAIT && bus.mem_busy) begin
      timer <= timer + 1'b1;
    end
  end

  // Command registers: pulses last exactly the ISSUE cycle, address/data held until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_byte_write <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_din        <= '0;
      cmd_write          <= 1'b0;
    end else begin
      bus.mem_read  <= pop && !head.write;
      bus.mem_write <= pop && head.write;
      if (pop) begin
        bus.mem_byte_write <= head.write && head.byte_w;
        bus.mem_addr       <= head.addr;
        bus.mem_din        <= head.data;
        cmd_write          <= head.write;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_byte  <= '0;
      timeout_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= done;
      if (done) begin
        bus.rsp_write <= cmd_write;
        bus.rsp_err   <= tmo;
        bus.rsp_data  <= cmd_write ? 16'h0000 : bus.mem_dout;
        bus.rsp_byte  <= cmd_write ? 8'h00 :
                         (bus.mem_addr[0] ? bus.mem_dout[15:8] : bus.mem_dout[7:0]);
      end
      if (tmo) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_psram_cmd_queue.sv
// Directed bench for psram_cmd_queue with a behavioural PsramController and an in-order response scoreboard.
module tb_psram_cmd_queue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       timeout_err;
  logic [2:0] level;
  logic [1:0] state_dbg;

  psram_cmd_queue_if bus ();

  psram_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .timeout_err (timeout_err),
    .level       (level),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard: {write, err, data, byte} ----------------
  logic [25:0] exp_q[$];
  int          rsp_cnt      = 0;
  int          last_rsp_cyc = 0;

  function automatic void expect_rsp(input logic w, input logic e, input logic [15:0] d, input logic [7:0] b);
    exp_q.push_back({w, e, d, b});
  endfunction

  initial forever begin
    logic [25:0] e;
    @(negedge clk);
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {6'b0, bus.rsp_write, bus.rsp_err, bus.rsp_data, bus.rsp_byte}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("rsp", {6'b0, bus.rsp_write, bus.rsp_err, bus.rsp_data, bus.rsp_byte}, {6'b0, e});
      end
    end
  end

  // ---------------- PsramController model ----------------
  int          lat        = 3;
  bit          force_busy = 1'b0;
  int          busy_cnt   = 0;
  int          pulse_cnt  = 0;
  int          pulse_cyc  = 0;
  bit          prev_pulse = 1'b0;
  logic [15:0] pmem [int];
  logic        pend_w, pend_b;
  logic [21:0] pend_addr;
  logic [15:0] pend_din;
  logic [15:0] last_din  = '0;
  logic        last_bw   = 1'b0;
  logic [21:0] last_addr = '0;

  initial begin
    int          idx;
    logic [15:0] word;
    bus.mem_busy = 1'b0;
    bus.mem_dout = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
        check("one_pulse", {31'b0, bus.mem_read & bus.mem_write}, 32'd0);
        check("pulse_width", {31'b0, prev_pulse}, 32'd0);
        prev_pulse = 1'b1;
        pulse_cnt++;
        pulse_cyc = cyc;
        pend_w    = bus.mem_write;
        pend_b    = bus.mem_byte_write;
        pend_addr = bus.mem_addr;
        pend_din  = bus.mem_din;
        last_din  = bus.mem_din;
        last_bw   = bus.mem_byte_write;
        last_addr = bus.mem_addr;
        busy_cnt  = lat;
      end else begin
        prev_pulse = 1'b0;
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            idx  = int'(pend_addr[21:1]);
            word = pmem.exists(idx) ? pmem[idx] : 16'h0000;
            if (pend_w) begin
              if (pend_b) begin
                if (pend_addr[0]) word[15:8] = pend_din[15:8];
                else              word[7:0]  = pend_din[7:0];
              end else begin
                word = pend_din;
              end
              pmem[idx] = word;
            end else begin
              bus.mem_dout = word;
            end
          end
        end
      end
      bus.mem_busy = force_busy || (busy_cnt != 0);
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after acceptance with req_valid low.
  task automatic send(input logic w, input logic b, input logic [21:0] a, input logic [15:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_byte  = b;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (bus.req_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", {31'b0, bus.req_ready}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic wait_pulse(input int p0);
    int n = 0;
    while (pulse_cnt == p0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pulse_seen", {31'b0, pulse_cnt != p0}, 32'd1);
  endtask

  function automatic logic [15:0] hash16(input int k);
    return 16'(k * 16'h1357) ^ 16'hA5C3;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int p0, r0, n;
    logic [15:0] h;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    tick(3);
    reset = 1'b0;

    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_pulses", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_level", {29'b0, level}, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    check("rst_rsp_data", {16'b0, bus.rsp_data}, 32'd0);
    check("rst_mem_addr", {10'b0, bus.mem_addr}, 32'd0);

    // Byte write then read at an odd address; fastest controller for the latency check.
    lat = 1;
    expect_rsp(1'b1, 1'b0, 16'h0000, 8'h00);
    send(1'b1, 1'b1, 22'h000005, 16'h00A5);
    drain(50);
    check("lat_pulse", pulse_cyc - acc_cyc, 32'd2);
    check("lat_rsp", last_rsp_cyc - acc_cyc, 32'd5);
    check("t1_din", {16'b0, last_din}, 32'h0000A5A5);
    check("t1_bw", {31'b0, last_bw}, 32'd1);
    check("t1_addr", {10'b0, last_addr}, 32'h5);
    lat = 3;
    expect_rsp(1'b0, 1'b0, 16'hA500, 8'hA5);
    send(1'b0, 1'b1, 22'h000005, 16'hFFFF);
    drain(50);
    check("t1_rd_bw", {31'b0, last_bw}, 32'd0);

    // Word write at the top address and read back.
    expect_rsp(1'b1, 1'b0, 16'h0000, 8'h00);
    send(1'b1, 1'b0, 22'h3FFFFF, 16'h1234);
    drain(50);
    check("t2_din", {16'b0, last_din}, 32'h00001234);
    check("t2_bw", {31'b0, last_bw}, 32'd0);
    check("t2_addr", {10'b0, last_addr}, 32'h3FFFFF);
    expect_rsp(1'b0, 1'b0, 16'h1234, 8'h12);
    send(1'b0, 1'b0, 22'h3FFFFF, 16'h0000);
    drain(50);

    // Fill the queue while busy is held high, then release.
    force_busy = 1'b1;
    tick(2);
    p0 = pulse_cnt;
    expect_rsp(1'b1, 1'b0, 16'h0000, 8'h00);
    expect_rsp(1'b1, 1'b0, 16'h0000, 8'h00);
    expect_rsp(1'b0, 1'b0, 16'hCAFE, 8'hFE);
    expect_rsp(1'b0, 1'b0, 16'hBEEF, 8'hEF);
    expect_rsp(1'b0, 1'b0, 16'hBEEF, 8'hBE);
    send(1'b1, 1'b0, 22'h000010, 16'hBEEF);
    send(1'b1, 1'b0, 22'h000012, 16'hCAFE);
    send(1'b0, 1'b0, 22'h000012, 16'h0000);
    send(1'b0, 1'b0, 22'h000010, 16'h0000);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 22'h000011;
    bus.req_wdata = 16'h0000;
    tick(3);
    check("t3_full_ready", {31'b0, bus.req_ready}, 32'd0);
    check("t3_level", {29'b0, level}, 32'd4);
    check("t3_no_pulse", pulse_cnt - p0, 32'd0);
    force_busy = 1'b0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t3_fifth_accept", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain(200);
    check("t3_pulses", pulse_cnt - p0, 32'd5);
    check("t3_level_end", {29'b0, level}, 32'd0);

    // Busy stuck high after a read pulse: timeout.
    p0 = pulse_cnt;
    r0 = rsp_cnt;
    expect_rsp(1'b0, 1'b1, 16'h1234, 8'h34);
    send(1'b0, 1'b0, 22'h3FFFFE, 16'h0000);
    wait_pulse(p0);
    force_busy = 1'b1;
    n = 0;
    while (rsp_cnt == r0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("t4_rsp_seen", rsp_cnt - r0, 32'd1);
    check("t4_timeout_cyc", last_rsp_cyc - pulse_cyc, 32'(TIMEOUT + 2));
    tick(5);
    check("t4_sticky", {31'b0, timeout_err}, 32'd1);
    force_busy = 1'b0;
    tick(3);
    check("t4_sticky_idle", {31'b0, timeout_err}, 32'd1);

    // Reset during WAIT with three commands queued.
    p0 = pulse_cnt;
    send(1'b1, 1'b0, 22'h000040, 16'h7777);
    wait_pulse(p0);
    force_busy = 1'b1;
    send(1'b0, 1'b0, 22'h000040, 16'h0000);
    send(1'b0, 1'b0, 22'h000010, 16'h0000);
    send(1'b0, 1'b0, 22'h000012, 16'h0000);
    check("t5_level_pre", {29'b0, level}, 32'd3);
    check("t5_in_wait", {30'b0, state_dbg}, 32'd3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_level", {29'b0, level}, 32'd0);
    check("t5_err_cleared", {31'b0, timeout_err}, 32'd0);
    check("t5_ready", {31'b0, bus.req_ready}, 32'd1);
    p0 = pulse_cnt;
    r0 = rsp_cnt;
    tick(40);
    check("t5_no_pulse_busy", pulse_cnt - p0, 32'd0);
    check("t5_no_rsp", rsp_cnt - r0, 32'd0);
    force_busy = 1'b0;
    tick(10);
    check("t5_no_pulse_idle", pulse_cnt - p0, 32'd0);
    expect_rsp(1'b0, 1'b0, 16'h7777, 8'h77);
    send(1'b0, 1'b0, 22'h000040, 16'h0000);
    drain(50);

    // Stream 10 writes then 10 reads through the 4-entry queue.
    for (int k = 0; k < 10; k++) begin
      expect_rsp(1'b1, 1'b0, 16'h0000, 8'h00);
      send(1'b1, 1'b0, 22'h000200 + 22'(2 * k), hash16(k));
    end
    for (int k = 0; k < 10; k++) begin
      h = hash16(k);
      expect_rsp(1'b0, 1'b0, h, h[7:0]);
      send(1'b0, 1'b0, 22'h000200 + 22'(2 * k), 16'h0000);
    end
    drain(500);
    check("t6_timeout_err", {31'b0, timeout_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
